// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame sequencer.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int PRESC_8  = 8;
    localparam int PRESC_16 = 16;
    localparam int PRESC_32 = 32;

    // Sampled bit is stable this many clocks after mid-bit.
    localparam int K_OFS = 2;

    function automatic int presc_sel(input int p);
        if (p == PRESC_8 || p == PRESC_16 || p == PRESC_32)
            return p;
        return PRESC_8;
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Edge counter (wraps at presc-1) and data-bit counter for the RX sequencer.
module uart_rx_edge_bit_cnt #(
    parameter int PRESC_W = 6,
    parameter int BIT_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cnt_en,
    input  logic               edge_clr,
    input  logic               bit_clr,
    input  logic               bit_inc,
    input  logic [PRESC_W-1:0] presc,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]   bit_cnt,
    output logic               bit_done
);

    assign bit_done = cnt_en && (edge_cnt == presc - PRESC_W'(1));

    always_ff @(posedge clk) begin
        if (rst)
            edge_cnt <= '0;
        else if (edge_clr)
            edge_cnt <= '0;
        else if (cnt_en)
            edge_cnt <= bit_done ? '0 : edge_cnt + PRESC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            bit_cnt <= '0;
        else if (bit_clr)
            bit_cnt <= '0;
        else if (bit_inc)
            bit_cnt <= bit_cnt + BIT_W'(1);
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX frame sequencer: start detect, checker/deserializer strobes and
// frame judgement into data_valid / frame_err.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_in,
    input  logic               par_en,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               strt_glitch,
    input  logic               par_err,
    input  logic               stop_err,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [3:0]         bit_cnt,
    output logic               dat_samp_en,
    output logic               strt_chk_en,
    output logic               par_chk_en,
    output logic               stop_chk_en,
    output logic               deser_en,
    output logic               data_valid,
    output logic               frame_err,
    output logic               busy
);

    rx_state_e          state;
    logic [PRESC_W-1:0] p_lat;
    logic [PRESC_W-1:0] p_new;
    logic [PRESC_W-1:0] k_pt;
    logic [PRESC_W-1:0] k_pre;
    logic [PRESC_W-1:0] k_post;
    logic               par_flag;
    logic               cnt_en;
    logic               edge_clr;
    logic               bit_clr;
    logic               bit_inc;
    logic               bit_done;
    logic               last_bit;
    logic               strb_pt;

    assign p_new    = PRESC_W'(presc_sel(int'(prescale)));
    assign k_pt     = (p_lat >> 1) + PRESC_W'(K_OFS);
    assign k_pre    = k_pt - PRESC_W'(1);
    assign k_post   = k_pt + PRESC_W'(1);
    assign last_bit = (bit_cnt == 4'(DATA_WIDTH - 1));
    assign cnt_en   = (state != IDLE);
    assign edge_clr = (state == IDLE) && !rx_in;
    assign bit_clr  = (state == START) && bit_done && !strt_glitch;
    assign bit_inc  = (state == DATA) && bit_done && !last_bit;
    // Strobes are registered, so arm them one clock ahead of edge K.
    assign strb_pt  = cnt_en && (edge_cnt == k_pre);

    uart_rx_edge_bit_cnt #(
        .PRESC_W (PRESC_W),
        .BIT_W   (4)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .cnt_en   (cnt_en),
        .edge_clr (edge_clr),
        .bit_clr  (bit_clr),
        .bit_inc  (bit_inc),
        .presc    (p_lat),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            p_lat       <= PRESC_W'(PRESC_8);
            par_flag    <= 1'b0;
            busy        <= 1'b0;
            dat_samp_en <= 1'b0;
            strt_chk_en <= 1'b0;
            par_chk_en  <= 1'b0;
            stop_chk_en <= 1'b0;
            deser_en    <= 1'b0;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            strt_chk_en <= (state == START)  && strb_pt;
            deser_en    <= (state == DATA)   && strb_pt;
            par_chk_en  <= (state == PARITY) && strb_pt;
            stop_chk_en <= (state == STOP)   && strb_pt;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_in) begin
                        state       <= START;
                        p_lat       <= p_new;
                        par_flag    <= 1'b0;
                        busy        <= 1'b1;
                        dat_samp_en <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done) begin
                        if (strt_glitch) begin
                            state       <= IDLE;
                            busy        <= 1'b0;
                            dat_samp_en <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (bit_done && last_bit)
                        state <= par_en ? PARITY : STOP;
                end
                PARITY: begin
                    if (edge_cnt == k_post)
                        par_flag <= par_err;
                    if (bit_done)
                        state <= STOP;
                end
                STOP: begin
                    if (bit_done) begin
                        data_valid <= !stop_err && !par_flag;
                        frame_err  <= stop_err || par_flag;
                        // Line already low at the stop boundary: next start bit.
                        if (!rx_in) begin
                            state    <= START;
                            p_lat    <= p_new;
                            par_flag <= 1'b0;
                        end else begin
                            state       <= IDLE;
                            busy        <= 1'b0;
                            dat_samp_en <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    dat_samp_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
